// File: rtl/core_muldiv_pkg.sv
// Shared definitions for the RV64M iterative multiply/divide unit:
// M-class ALU control codes and the per-code operation decode.
package core_muldiv_pkg;

    localparam int ALU_CTRL_WIDTH = 5;

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MUL   = 5'b10000;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MULH  = 5'b10001;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MULHU = 5'b10010;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MULSU = 5'b10011;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_DIVU  = 5'b10100;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_REM   = 5'b10101;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_DIV   = 5'b10110;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_REMU  = 5'b10111;

    typedef struct packed {
        logic legal;    // one of the eight M-class codes
        logic is_div;   // divide/remainder family
        logic is_rem;   // remainder rather than quotient
        logic sgn_a;    // op_a interpreted as signed
        logic sgn_b;    // op_b interpreted as signed
        logic take_hi;  // result is the upper half of the product
    } md_dec_t;

    function automatic md_dec_t md_decode(input logic [ALU_CTRL_WIDTH-1:0] code);
        md_dec_t d;
        case (code)
            ALU_MUL:   d = md_dec_t'(6'b100110);
            ALU_MULH:  d = md_dec_t'(6'b100111);
            ALU_MULHU: d = md_dec_t'(6'b100001);
            ALU_MULSU: d = md_dec_t'(6'b100101);
            ALU_DIVU:  d = md_dec_t'(6'b110000);
            ALU_REM:   d = md_dec_t'(6'b111110);
            ALU_DIV:   d = md_dec_t'(6'b110110);
            ALU_REMU:  d = md_dec_t'(6'b111000);
            default:   d = md_dec_t'(6'b000000);
        endcase
        return d;
    endfunction

endpackage

// File: rtl/core_muldiv_neg.sv
// Combinational conditional two's-complement negator; used for operand
// magnitudes and for the final sign fix-up.
module core_muldiv_neg #(
    parameter int W = 64
) (
    input  logic         neg,
    input  logic [W-1:0] val,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/core_muldiv.sv
// Iterative RV64M execution unit: radix-2 shift-add multiply and restoring
// divide on magnitudes, one sign fix-up cycle, valid/ready on both sides.
module core_muldiv
    import core_muldiv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
    input  logic [XLEN-1:0]           op_a,
    input  logic [XLEN-1:0]           op_b,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_r, state_n_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   hi_r, lo_r, mc_r, result_r;
    logic              is_div_r, is_rem_r, take_hi_r, neg_r;
    logic              in_ready_r, out_valid_r;

    md_dec_t           dec_s;
    logic              sign_a_s, sign_b_s, div_zero_s, div_ovf_s, special_s, neg_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s, special_res_s;
    logic [XLEN:0]     mul_sum_s, div_shl_s;
    logic [XLEN-1:0]   div_diff_s, step_hi_s, step_lo_s, fix_res_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] fix_in_s, fix_out_s;

    assign dec_s      = md_decode(alu_ctrl);
    assign sign_a_s   = dec_s.sgn_a & op_a[XLEN-1];
    assign sign_b_s   = dec_s.sgn_b & op_b[XLEN-1];
    assign div_zero_s = dec_s.is_div & (op_b == {XLEN{1'b0}});
    assign div_ovf_s  = dec_s.is_div & dec_s.sgn_a & (op_a == SMIN) & (op_b == {XLEN{1'b1}});
    assign special_s  = ~dec_s.legal | div_zero_s | div_ovf_s;
    // Remainder follows the dividend; quotient and product follow the sign XOR.
    assign neg_s      = (dec_s.is_div & dec_s.is_rem) ? sign_a_s : (sign_a_s ^ sign_b_s);

    core_muldiv_neg #(.W(XLEN)) u_mag_a (.neg(sign_a_s), .val(op_a), .res(mag_a_s));
    core_muldiv_neg #(.W(XLEN)) u_mag_b (.neg(sign_b_s), .val(op_b), .res(mag_b_s));

    // Results that bypass the iteration (illegal code, divide by zero, overflow).
    always_comb begin
        special_res_s = {XLEN{1'b0}};
        if (!dec_s.legal) begin
            special_res_s = {XLEN{1'b0}};
        end else if (div_zero_s) begin
            special_res_s = dec_s.is_rem ? op_a : {XLEN{1'b1}};
        end else if (div_ovf_s) begin
            special_res_s = dec_s.is_rem ? {XLEN{1'b0}} : SMIN;
        end else begin
            special_res_s = {XLEN{1'b0}};
        end
    end

    // One iteration: hi_r holds the partial product / running remainder,
    // lo_r the multiplier bits / dividend-then-quotient bits.
    always_comb begin
        mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mc_r} : {(XLEN+1){1'b0}});
        div_shl_s  = {hi_r, lo_r[XLEN-1]};
        div_ge_s   = (div_shl_s >= {1'b0, mc_r});
        div_diff_s = div_shl_s[XLEN-1:0] - mc_r;
        if (is_div_r) begin
            step_hi_s = div_ge_s ? div_diff_s : div_shl_s[XLEN-1:0];
            step_lo_s = {lo_r[XLEN-2:0], div_ge_s};
        end else begin
            step_hi_s = mul_sum_s[XLEN:1];
            step_lo_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    assign fix_in_s  = is_div_r ? {{XLEN{1'b0}}, (is_rem_r ? hi_r : lo_r)} : {hi_r, lo_r};
    core_muldiv_neg #(.W(2*XLEN)) u_fix (.neg(neg_r), .val(fix_in_s), .res(fix_out_s));
    assign fix_res_s = take_hi_r ? fix_out_s[2*XLEN-1:XLEN] : fix_out_s[XLEN-1:0];

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_n_s = special_s ? ST_DONE : ST_CALC;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_n_s = ST_FIX;
                end else begin
                    state_n_s = ST_CALC;
                end
            end
            ST_FIX:  state_n_s = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_DONE;
                end
            end
            default: state_n_s = ST_IDLE;
        endcase
        if (flush) begin
            state_n_s = ST_IDLE;
        end else begin
            state_n_s = state_n_s;
        end
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            hi_r        <= {XLEN{1'b0}};
            lo_r        <= {XLEN{1'b0}};
            mc_r        <= {XLEN{1'b0}};
            result_r    <= {XLEN{1'b0}};
            is_div_r    <= 1'b0;
            is_rem_r    <= 1'b0;
            take_hi_r   <= 1'b0;
            neg_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            in_ready_r  <= (state_n_s == ST_IDLE);
            out_valid_r <= (state_n_s == ST_DONE);
            if (flush) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (in_valid) begin
                            cnt_r     <= {CNT_W{1'b0}};
                            is_div_r  <= dec_s.is_div;
                            is_rem_r  <= dec_s.is_rem;
                            take_hi_r <= dec_s.take_hi;
                            neg_r     <= neg_s;
                            hi_r      <= {XLEN{1'b0}};
                            lo_r      <= dec_s.is_div ? mag_a_s : mag_b_s;
                            mc_r      <= dec_s.is_div ? mag_b_s : mag_a_s;
                            if (special_s) begin
                                result_r <= special_res_s;
                            end
                        end
                    end
                    ST_CALC: begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        hi_r  <= step_hi_s;
                        lo_r  <= step_lo_s;
                    end
                    ST_FIX:  result_r <= fix_res_s;
                    default: cnt_r <= cnt_r;
                endcase
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_core_muldiv.sv
// Self-checking bench for core_muldiv: arithmetic reference model plus a
// per-cycle compare process, driven by directed vectors.
module tb_core_muldiv;
    import core_muldiv_pkg::*;

    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [4:0]  alu_ctrl = 5'd0;
    logic [63:0] op_a = 64'd0, op_b = 64'd0;
    logic        in_ready, out_valid;
    logic [63:0] result;

    core_muldiv dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0, cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%016h required=0x%016h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ub;
        logic [127:0]        p;
        logic signed [63:0]  as, bs;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ub = {64'd0, b};
        as = a;
        bs = b;
        case (c)
            ALU_MUL:   begin p = sa * sb; return p[63:0]; end
            ALU_MULH:  begin p = sa * sb; return p[127:64]; end
            ALU_MULHU: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            ALU_MULSU: begin p = sa * ub; return p[127:64]; end
            ALU_DIV:   return (b == 64'd0) ? ONES : ((a == MIN && b == ONES) ? MIN : 64'(as / bs));
            ALU_REM:   return (b == 64'd0) ? a : ((a == MIN && b == ONES) ? 64'd0 : 64'(as % bs));
            ALU_DIVU:  return (b == 64'd0) ? ONES : a / b;
            ALU_REMU:  return (b == 64'd0) ? a : a % b;
            default:   return 64'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b);
        if (!(c inside {ALU_MUL, ALU_MULH, ALU_MULHU, ALU_MULSU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU})) return 1;
        if ((c inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) && b == 64'd0) return 1;
        if ((c inside {ALU_DIV, ALU_REM}) && a == MIN && b == ONES) return 1;
        return 66;
    endfunction

    // Compare process: every cycle with out_valid high is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk(1'b0, "spurious_valid", result, 64'd0);
                end else begin
                    chk(result == q[0].res, "result", result, q[0].res);
                    chk(!in_ready, "in_ready_in_done", {63'd0, in_ready}, 64'd0);
                    if (!prev_valid)
                        chk((cyc - q[0].acc + 1) == q[0].lat, "latency",
                            64'(cyc - q[0].acc + 1), 64'(q[0].lat));
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic issue(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(in_ready, "issue_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        q.push_back('{res: model(c, a, b), lat: model_lat(c, a, b), acc: cyc});
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int hold);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(out_valid, "done_timeout", {63'd0, out_valid}, 64'd1);
        if (out_valid) begin
            repeat (hold) @(negedge clk);
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            if (q.size() != 0) void'(q.pop_front());
            chk(!out_valid, "valid_after_hs", {63'd0, out_valid}, 64'd0);
            chk(in_ready, "ready_after_hs", {63'd0, in_ready}, 64'd1);
        end else begin
            q.delete();
        end
    endtask

    task automatic run(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] lit, input int hold);
        chk(model(c, a, b) == lit, "model_pin", model(c, a, b), lit);
        issue(c, a, b);
        wait_done(hold);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk(in_ready, "reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk(!out_valid, "reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk(result == 64'd0, "reset_result", result, 64'd0);
        rst_n = 1'b1;

        run(ALU_MUL,   -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        run(ALU_MULHU, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run(ALU_MULH,  ONES, ONES, 64'd0, 0);
        run(ALU_MULSU, ONES, 64'd2, ONES, 0);
        run(ALU_MULH,  MIN, MIN, 64'h4000_0000_0000_0000, 0);
        run(ALU_MULSU, MIN, ONES, 64'h8000_0000_0000_0000, 0);
        run(ALU_DIV,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run(ALU_REM,   -64'sd7, 64'd2, ONES, 0);
        run(ALU_DIV,   64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run(ALU_REM,   64'd7, -64'sd2, 64'd1, 0);
        run(ALU_DIVU,  64'd100, 64'd7, 64'd14, 0);
        run(ALU_REMU,  64'd100, 64'd7, 64'd2, 0);
        run(ALU_DIVU,  ONES, 64'd1, ONES, 0);
        run(ALU_REMU,  ONES, 64'd3, 64'd0, 0);
        run(ALU_DIV,   64'd12345, 64'd0, ONES, 0);
        run(ALU_REM,   64'd5, 64'd0, 64'd5, 0);
        run(ALU_DIVU,  64'd9, 64'd0, ONES, 0);
        run(ALU_DIV,   MIN, ONES, MIN, 0);
        run(ALU_REM,   MIN, ONES, 64'd0, 0);
        run(5'b11111,  64'd3, 64'd4, 64'd0, 0);
        run(5'b01010,  64'd3, 64'd4, 64'd0, 0);

        // Held result: stable with in_ready low, then immediate re-issue.
        run(ALU_MUL, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
            model(ALU_MUL, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321), 10);
        run(ALU_DIV, MIN, 64'd2, 64'hC000_0000_0000_0000, 0);

        // Flush during CALC.
        issue(ALU_MUL, 64'd11, 64'd13);
        repeat (30) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        q.delete();
        chk(!out_valid, "flush_valid", {63'd0, out_valid}, 64'd0);
        chk(in_ready, "flush_ready", {63'd0, in_ready}, 64'd1);
        repeat (80) @(negedge clk);
        chk(!out_valid, "flush_no_result", {63'd0, out_valid}, 64'd0);

        // Flush beats out_ready and in_valid in DONE.
        issue(5'b11111, 64'd1, 64'd1);
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_ctrl  = ALU_DIV;
        op_a      = 64'd5;
        op_b      = 64'd0;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        q.delete();
        chk(!out_valid, "flush_prio_valid", {63'd0, out_valid}, 64'd0);
        chk(in_ready, "flush_prio_ready", {63'd0, in_ready}, 64'd1);
        repeat (5) @(negedge clk);
        chk(!out_valid, "flush_prio_noacc", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset during CALC.
        issue(ALU_DIVU, 64'd100, 64'd7);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk(!out_valid, "rst_mid_valid", {63'd0, out_valid}, 64'd0);
        chk(in_ready, "rst_mid_ready", {63'd0, in_ready}, 64'd1);
        chk(result == 64'd0, "rst_mid_result", result, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(ALU_REMU, 64'd100, 64'd7, 64'd2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_muldiv.md
Name: core_muldiv

Overview:
Iterative RV64M execution unit. It consumes the 5-bit M-class ALU control codes produced by the ALU control decoder, and the two 64-bit operands, and returns the 64-bit result over a valid/ready handshake. It sits in EX beside the single-cycle ALU. The pipeline stalls EX while in_ready=0 or while a result is pending.

Parameters:
XLEN, 64, operand/result width
CNT_W, 7, iteration counter width (must hold XLEN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  async active-low reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept request
alu_ctrl  in  `ALU_CTRL_WIDTH  operation code (MUL..REMU)
op_a  in  XLEN  rs1 value
op_b  in  XLEN  rs2 value
flush  in  1  kill in-flight op (pipeline redirect)
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
result  out  XLEN  result

Behaviour:
- Reset: clk and rst_n as named above; rst_n low asynchronously forces state=IDLE, in_ready=1, out_valid=0, result=0, counter=0. Reset mid-operation abandons the op with no output.
- Codes:
  - MUL=10000 (low 64 of product)
  - MULH=10001 (s×s, high)
  - MULSU=10011 (s×u, high)
  - MULHU=10010 (u×u, high)
  - DIV=10110, DIVU=10100, REM=10101, REMU=10111
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1, latch the operands and code.
  - Take magnitudes of signed operands and record the result sign.
  - Go to CALC with counter=0.
  - Special divide cases go directly to DONE, with the result registered in the same edge:
    - Divisor 0: DIV/DIVU give all-ones; REM/REMU give op_a.
    - DIV with op_a=0x8000_0000_0000_0000 and op_b=all-ones: quotient=op_a, REM=0.
  - Any code with alu_ctrl[4]=0 or equal to 11111: go to DONE with result=0 (illegal; must not hang).
- CALC: one iteration per cycle, XLEN iterations; counter increments and leaves at counter==XLEN-1.
  - Multiply: radix-2 shift-add on a 2·XLEN accumulator of magnitudes.
  - Divide: restoring division of magnitudes; 64-bit remainder register plus 1 carry bit.
- FIX: one cycle; conditional two's-complement negation, then select the output.
  - Product is negated if the signs differ (MULSU: only op_a is signed).
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Go to DONE.
- DONE:
  - out_valid=1; result is held stable until out_ready=1.
  - On the handshake go to IDLE.
  - in_ready=0 in DONE (no back-to-back overlap).
- Latency, accept edge to out_valid:
  - Normal ops: XLEN+2 cycles (66).
  - Special/illegal ops: 1 cycle.
- in_ready=0 in CALC, FIX and DONE; in_valid is ignored there.
- flush=1 in any state: synchronous return to IDLE, out_valid=0 next cycle, result discarded.
  - flush has priority over out_ready and in_valid in the same cycle; no request is accepted that cycle.
- Unsigned ops never negate. The signed magnitude of MIN is MIN treated as unsigned.
- All outputs are registered.

Decomposition:
- Move the M-class ALU code `defines into defines.v (MUL..REMU, DFT) so the decoder and this unit share one source.
- State encoding and XLEN-related localparams stay local.
- One natural sub-module: core_muldiv_neg, a combinational conditional two's-complement negator. It is instanced for operand magnitudes and for the FIX stage.

Test Plan:
- MUL op_a=-3, op_b=7 -> after 66 cycles result=0xFFFF_FFFF_FFFF_FFEB; MULHU of all-ones×all-ones -> 0xFFFF_FFFF_FFFF_FFFE.
- MULH of -1×-1 -> 0; MULSU op_a=-1, op_b=2 -> all-ones; MULH 0x8000..0×0x8000..0 -> 0x4000_0000_0000_0000.
- DIV -7/2 -> -3 (0xFFFF...FFFD); REM -7/2 -> -1; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV x/0 -> all-ones, REM 5/0 -> 5, DIV MIN/-1 -> MIN, REM MIN/-1 -> 0; all with out_valid one cycle after accept.
- Hold out_ready=0 for 10 cycles after out_valid -> result stable and in_ready=0; release -> IDLE; new request accepted the next cycle.
- flush at CALC cycle 30 -> no out_valid, in_ready=1 next cycle; rst_n low at CALC cycle 10 -> immediate IDLE, out_valid=0; alu_ctrl=11111 -> result 0 after 1 cycle.
